// File: rtl/conv_frame_scheduler.sv
// Frame sequencer for the stride-2 2x2 convolution datapath: load the frame,
// issue windows under an in-flight cap, collect results, then signal done.
module conv_frame_scheduler #(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 360,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned PIX_AW    = $clog2(IMG_W * IMG_H),
    parameter int unsigned OUT_AW    = $clog2((IMG_W / 2) * (IMG_H / 2))
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       wr_en_o,
    output logic [PIX_AW-1:0]          wr_addr_o,
    output logic                       win_valid_o,
    input  logic                       win_ready_i,
    output logic [$clog2(IMG_W)-1:0]   win_x_o,
    output logic [$clog2(IMG_H)-1:0]   win_y_o,
    input  logic                       res_valid_i,
    output logic                       res_we_o,
    output logic [OUT_AW-1:0]          res_addr_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);
    localparam int unsigned N_PIX = IMG_W * IMG_H;
    localparam int unsigned N_WIN = (IMG_W / 2) * (IMG_H / 2);
    // result counter must reach N_WIN itself, one more than the last address
    localparam int unsigned RW    = $clog2(N_WIN + 1);
    localparam int unsigned OW    = $clog2(MAX_OUTST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [PIX_AW-1:0]   pix_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [OW-1:0]       outst_q;
    logic [RW-1:0]       res_q;
    logic                err_q;

    logic                pix_acc;
    logic                win_hs;
    logic                res_ok;
    logic                err_set;
    logic                last_pix;
    logic                last_x;
    logic                last_y;

    // Handshake decode and error detection from the current state
    always_comb begin
        pix_acc  = (state_q == S_LOAD) && in_valid_i;
        win_hs   = win_valid_o && win_ready_i;
        res_ok   = res_valid_i && (outst_q != OW'(0))
                   && ((state_q == S_COMPUTE) || (state_q == S_FLUSH));
        last_pix = (pix_q == PIX_AW'(N_PIX - 1));
        last_x   = (x_q == XW'(IMG_W - 2));
        last_y   = (y_q == YW'(IMG_H - 2));
        err_set  = (res_valid_i && ((outst_q == OW'(0)) || (state_q == S_IDLE)
                                    || (state_q == S_LOAD) || (state_q == S_DONE)))
                   || (start_i && busy_o);
    end

    // Output decode; write strobes follow the input handshakes in the same cycle
    assign in_ready_o  = (state_q == S_LOAD);
    assign wr_en_o     = pix_acc;
    assign wr_addr_o   = pix_q;
    assign win_valid_o = (state_q == S_COMPUTE) && (outst_q < OW'(MAX_OUTST));
    assign win_x_o     = x_q;
    assign win_y_o     = y_q;
    assign res_we_o    = res_ok;
    assign res_addr_o  = OUT_AW'(res_q);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;

    // Frame state machine with its pixel, window, in-flight and result counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            outst_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (abort_i && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                pix_q   <= '0;
                x_q     <= '0;
                y_q     <= '0;
                outst_q <= '0;
                res_q   <= '0;
            end else begin
                case ({win_hs, res_ok})
                    2'b10:   outst_q <= outst_q + OW'(1);
                    2'b01:   outst_q <= outst_q - OW'(1);
                    default: ;
                endcase
                if (res_ok) begin
                    res_q <= res_q + RW'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q <= S_LOAD;
                            pix_q   <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                            outst_q <= '0;
                            res_q   <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (pix_acc) begin
                            if (last_pix) begin
                                state_q <= S_COMPUTE;
                            end else begin
                                pix_q <= pix_q + PIX_AW'(1);
                            end
                        end
                    end
                    S_COMPUTE: begin
                        if (win_hs) begin
                            if (last_x) begin
                                if (last_y) begin
                                    state_q <= S_FLUSH;
                                end else begin
                                    x_q <= '0;
                                    y_q <= y_q + YW'(2);
                                end
                            end else begin
                                x_q <= x_q + XW'(2);
                            end
                        end
                    end
                    S_FLUSH: begin
                        if ((res_q == RW'(N_WIN)) && (outst_q == OW'(0))) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: reset/control vector table, directed frame
// scenarios and randomized frames checked against an event-level frame model.
module tb_conv_frame_scheduler;

    localparam int unsigned W      = 8;
    localparam int unsigned H      = 4;
    localparam int unsigned MO     = 2;
    localparam int unsigned NP     = W * H;
    localparam int unsigned NW     = (W / 2) * (H / 2);
    localparam int          BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_i, start_i, abort_i, in_valid_i, win_ready_i, res_valid_i;
    logic       in_ready_o, wr_en_o, win_valid_o, res_we_o, busy_o, done_o, err_o;
    logic [4:0] wr_addr_o;
    logic [2:0] win_x_o;
    logic [1:0] win_y_o;
    logic [2:0] res_addr_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    conv_frame_scheduler #(
        .IMG_W(W), .IMG_H(H), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o), .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
        .win_x_o(win_x_o), .win_y_o(win_y_o), .res_valid_i(res_valid_i),
        .res_we_o(res_we_o), .res_addr_o(res_addr_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        logic       rst, start, abort, in_valid, res_valid;
        logic       in_ready, wr_en;
        logic [4:0] wr_addr;
        logic       busy, done, err, win_valid, res_we;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic rst, input logic st, input logic ab,
                                input logic iv, input logic rv, input logic ir,
                                input logic we, input int addr, input logic bz,
                                input logic er);
        vec_t v;
        v.rst = rst; v.start = st; v.abort = ab; v.in_valid = iv; v.res_valid = rv;
        v.in_ready = ir; v.wr_en = we; v.wr_addr = 5'(addr); v.busy = bz;
        v.done = 1'b0; v.err = er; v.win_valid = 1'b0; v.res_we = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0;
        win_ready_i = 1'b0; res_valid_i = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        exp_err = 1'b0;
    endtask

    // One frame: start, then per cycle compare against counts of accepted
    // pixels, issued windows and returned results kept by the bench.
    task automatic run_frame(input int p_valid, input bit alt, input int p_ready,
                             input int lat_lo, input int lat_hi,
                             input int stall_x, input int stall_y,
                             input int abort_k, input int spur_k, input int exp_first);
        int writes, issued, returned, done_cnt, stall_cnt, first_issued, lat;
        bit aborted, prev_done, prev_wv, prev_rdy, stall_done, spur_done, alt_ph;
        bit finished, in_load, exp_wv, spur_now, abort_now;
        logic [2:0] prev_x;
        logic [1:0] prev_y;
        int q[$];
        writes = 0; issued = 0; returned = 0; done_cnt = 0; stall_cnt = 0;
        first_issued = -1; aborted = 0; prev_done = 0; prev_wv = 0; prev_rdy = 0;
        stall_done = 0; spur_done = 0; alt_ph = 1; finished = 0;
        prev_x = '0; prev_y = '0;

        @(negedge clk);
        idle_inputs();
        start_i = 1'b1;
        #1;
        check("start_from_idle_busy", 32'(busy_o), 0);

        for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            @(negedge clk);
            idle_inputs();
            if (aborted) begin
                check("abort_next_cycle", 32'({busy_o, win_valid_o, done_o}), 0);
                q.delete();
                finished = 1;
            end else if (prev_done) begin
                check("busy_after_done", 32'(busy_o), 0);
                check("done_single_cycle", 32'(done_o), 0);
                finished = 1;
            end else begin
                in_load = (writes < int'(NP));
                check("busy", 32'(busy_o), 1);
                check("in_ready", 32'(in_ready_o), 32'(in_load));
                if (in_load) check("wr_addr", 32'(wr_addr_o), 32'(writes));
                exp_wv = (writes == int'(NP)) && (issued < int'(NW))
                         && ((issued - returned) < int'(MO));
                check("win_valid", 32'(win_valid_o), 32'(exp_wv));
                if (prev_wv && !prev_rdy)
                    check("win_hold", 32'({win_valid_o, win_x_o, win_y_o}),
                          32'({1'b1, prev_x, prev_y}));
                check("err", 32'(err_o), 32'(exp_err));
                if (done_o) begin
                    done_cnt++;
                    check("done_after_all_results", 32'(returned), NW);
                    prev_done = 1;
                end

                abort_now = (abort_k >= 0) && (issued == abort_k);
                spur_now  = (spur_k >= 0) && in_load && (writes == spur_k) && !spur_done;
                if (in_load) begin
                    in_valid_i = alt ? alt_ph : ($urandom_range(99, 0) < 32'(p_valid));
                    alt_ph = ~alt_ph;
                end else begin
                    in_valid_i = ($urandom_range(99, 0) < 30);
                end
                if (abort_now) begin
                    win_ready_i = 1'b0;
                end else if (stall_cnt > 0) begin
                    win_ready_i = 1'b0;
                    stall_cnt--;
                end else if (win_valid_o && (int'(win_x_o) == stall_x)
                             && (int'(win_y_o) == stall_y) && !stall_done) begin
                    win_ready_i = 1'b0;
                    stall_cnt = 4;
                    stall_done = 1;
                end else begin
                    win_ready_i = ($urandom_range(99, 0) < 32'(p_ready));
                end
                res_valid_i = spur_now || (!abort_now && (q.size() > 0) && (q[0] <= cyc));
                abort_i = abort_now;
                #1;
                check("wr_en", 32'(wr_en_o), 32'(in_valid_i && in_load));
                if (in_valid_i && in_load) writes++;
                if (res_valid_i && spur_now) begin
                    check("spurious_res_we", 32'(res_we_o), 0);
                end else if (res_valid_i) begin
                    check("res_we", 32'(res_we_o), 1);
                    check("res_addr", 32'(res_addr_o), 32'(returned));
                    if (returned == 0) first_issued = issued;
                    returned++;
                    void'(q.pop_front());
                end else begin
                    check("res_we_quiet", 32'(res_we_o), 0);
                end
                if (exp_wv && win_ready_i) begin
                    check("win_x", 32'(win_x_o), 32'(2 * (issued % int'(W / 2))));
                    check("win_y", 32'(win_y_o), 32'(2 * (issued / int'(W / 2))));
                    lat = int'($urandom_range(32'(lat_hi), 32'(lat_lo)));
                    q.push_back(cyc + lat);
                    issued++;
                end
                if (abort_now) aborted = 1;
                if (spur_now) begin
                    spur_done = 1;
                    exp_err = 1'b1;
                end
                prev_wv = win_valid_o; prev_rdy = win_ready_i;
                prev_x = win_x_o; prev_y = win_y_o;
            end
        end
        if (!finished) check("frame_timeout", 0, 1);
        else if (!aborted) check("done_count", 32'(done_cnt), 1);
        else check("abort_no_done", 32'(done_cnt), 0);
        if (exp_first >= 0) check("windows_before_first_result", 32'(first_issued), 32'(exp_first));
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] act, exp;
        rst_i = 1'b1;
        idle_inputs();

        vecs[0]  = mk(0,0,0,0,0, 0,0,0,0,0);
        vecs[1]  = mk(0,0,1,0,0, 0,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,1, 0,0,0,0,0);
        vecs[3]  = mk(0,0,0,0,0, 0,0,0,0,1);
        vecs[4]  = mk(1,0,0,0,0, 0,0,0,0,1);
        vecs[5]  = mk(0,0,0,0,0, 0,0,0,0,0);
        vecs[6]  = mk(0,1,0,0,0, 0,0,0,0,0);
        vecs[7]  = mk(0,0,0,1,0, 1,1,0,1,0);
        vecs[8]  = mk(0,0,0,0,0, 1,0,1,1,0);
        vecs[9]  = mk(0,0,0,1,0, 1,1,1,1,0);
        vecs[10] = mk(0,1,0,0,0, 1,0,2,1,0);
        vecs[11] = mk(0,0,0,0,1, 1,0,2,1,1);
        vecs[12] = mk(0,0,1,0,0, 1,0,2,1,1);
        vecs[13] = mk(0,0,0,0,0, 0,0,0,0,1);
        vecs[14] = mk(0,1,1,0,0, 0,0,0,0,1);
        vecs[15] = mk(0,0,0,0,0, 1,0,0,1,1);
        vecs[16] = mk(1,0,0,0,0, 1,0,0,1,1);
        vecs[17] = mk(0,0,0,0,0, 0,0,0,0,0);

        reset_dut();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_i = vecs[i].rst; start_i = vecs[i].start; abort_i = vecs[i].abort;
            in_valid_i = vecs[i].in_valid; res_valid_i = vecs[i].res_valid;
            win_ready_i = 1'b0;
            #1;
            act = {in_ready_o, wr_en_o, wr_addr_o, busy_o, done_o, err_o, win_valid_o, res_we_o};
            exp = {vecs[i].in_ready, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].busy,
                   vecs[i].done, vecs[i].err, vecs[i].win_valid, vecs[i].res_we};
            check($sformatf("vector_%0d", i), 32'(act), 32'(exp));
        end

        // nominal frame: back-to-back pixels, engine always ready, 3-cycle latency
        reset_dut();
        run_frame(100, 0, 100, 3, 3, -1, -1, -1, -1, -1);
        // window (4,0) held off for 5 cycles
        run_frame(100, 0, 100, 3, 3, 4, 0, -1, -1, -1);
        // long engine latency: cap of 2 reached before the first result
        run_frame(100, 0, 100, 12, 12, -1, -1, -1, -1, 2);
        // alternating pixel valid
        run_frame(100, 1, 100, 3, 3, -1, -1, -1, -1, -1);
        // abort after 3 windows, then a clean restart from pixel 0
        run_frame(100, 0, 100, 3, 3, -1, -1, 3, -1, -1);
        run_frame(100, 0, 100, 3, 3, -1, -1, -1, -1, -1);
        // spurious result during LOAD: sticky error through completion
        run_frame(100, 0, 100, 2, 4, -1, -1, -1, 5, -1);
        @(negedge clk);
        #1;
        check("err_sticky_after_frame", 32'(err_o), 1);
        reset_dut();
        @(negedge clk);
        #1;
        check("err_cleared_by_reset", 32'(err_o), 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int lo;
            lo = int'($urandom_range(3, 1));
            run_frame(int'($urandom_range(100, 30)), 0, int'($urandom_range(100, 30)),
                      lo, lo + int'($urandom_range(5, 0)), -1, -1, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_frame_scheduler.md
Name: conv_frame_scheduler

Overview:
- Sequences one frame through the stride-2, 2x2 convolution datapath.
- Phase 1: accepts the input pixel stream and writes it into frame memory.
- Phase 2: issues window coordinates to the convolution engine and tracks results returned over its pipeline, bounding the number of in-flight windows.
- Phase 3: waits for all results, pulses done, and returns idle; sits between the pixel source, the frame RAM and the conv engine.

Parameters:
- IMG_W, 640, frame width in pixels; even, >=2.
- IMG_H, 360, frame height in pixels; even, >=2.
- MAX_OUTST, 4, maximum windows issued but not yet returned; 1..15.
- PIX_AW, $clog2(IMG_W*IMG_H), input frame address width.
- OUT_AW, $clog2((IMG_W/2)*(IMG_H/2)), output address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a frame; honoured only in IDLE.
- abort_i  in  1  cancel the current frame.
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  scheduler accepts a pixel.
- wr_en_o  out  1  frame RAM write strobe.
- wr_addr_o  out  PIX_AW  frame RAM write address (raster order).
- win_valid_o  out  1  window request valid.
- win_ready_i  in  1  engine accepts the window.
- win_x_o  out  $clog2(IMG_W)  window top-left column.
- win_y_o  out  $clog2(IMG_H)  window top-left row.
- res_valid_i  in  1  engine returns one result.
- res_we_o  out  1  output RAM write strobe (equals res_valid_i while in COMPUTE or FLUSH).
- res_addr_o  out  OUT_AW  output RAM address, raster order.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and all counters (pixel, x, y, outstanding, result) are 0. err_o is cleared only by rst_i.
- State machine: IDLE -> LOAD -> COMPUTE -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start_i=1 moves to LOAD next cycle and clears all counters.
  - in_ready_o=0, win_valid_o=0.
- LOAD:
  - in_ready_o=1. On in_valid_i, wr_en_o=1 combinationally and wr_addr_o = pixel counter; the counter increments on the next edge.
  - On accepting pixel IMG_W*IMG_H-1, move to COMPUTE next cycle.
- COMPUTE:
  - win_valid_o = (outstanding < MAX_OUTST). Coordinates are registered and stable while win_valid_o=1 and win_ready_i=0.
  - On handshake: x += 2. If x == IMG_W-2, x wraps to 0 and y += 2.
  - Handshake at (IMG_W-2, IMG_H-2) is the last window: move to FLUSH; win_valid_o is 0 from the next cycle.
- FLUSH:
  - Hold until result count == (IMG_W/2)*(IMG_H/2) and outstanding == 0, then go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, busy_o stays 1, then go to IDLE.
- Outstanding counter:
  - +1 on a window handshake, -1 on res_valid_i; a simultaneous handshake and res_valid_i leaves it unchanged.
  - Window issue stalls while the counter equals MAX_OUTST.
- Result counter:
  - Increments on each res_valid_i in COMPUTE or FLUSH; res_addr_o = result counter, so a write lands at the current value.
- err_o is set by any of:
  - res_valid_i when outstanding == 0 (the result is ignored: no res_we_o, no count);
  - res_valid_i in IDLE, LOAD or DONE;
  - start_i while busy_o=1 (start_i is otherwise ignored).
- Arithmetic:
  - All counters are unsigned and never exceed their terminal values; there is no modulo wrap beyond the frame.
  - y is compared only at x wrap.
- abort_i:
  - In any non-IDLE state, go to IDLE next cycle and clear all counters.
  - No done_o. Handshake outputs drop in the cycle after abort_i is sampled.
  - abort_i in IDLE has no effect.
  - abort_i has priority over start_i and over all state transitions.
- rst_i has priority over everything, including mid-frame.

Test Plan:
- Use IMG_W=8, IMG_H=4, MAX_OUTST=2.
- Nominal frame: start_i, stream 32 pixels back-to-back; engine always ready and returns each result 3 cycles after accept.
  - Required: wr_addr_o runs 0..31.
  - Windows issue in order (0,0),(2,0),(4,0),(6,0),(0,2),(2,2),(4,2),(6,2).
  - res_addr_o runs 0..7; done_o pulses once; busy_o falls the cycle after done_o.
- Backpressure: win_ready_i low for 5 cycles at window (4,0) -> win_x_o=4, win_y_o=0 held stable; no skipped or duplicated window.
- Outstanding cap: engine accepts but returns nothing for 10 cycles -> exactly 2 windows accepted, then win_valid_o=0 until the first res_valid_i.
- Input gaps: in_valid_i toggled 1,0,1,0 during LOAD -> wr_en_o follows in_valid_i; 32 writes total; COMPUTE is entered only after the 32nd write.
- Abort during COMPUTE after 3 windows -> next cycle busy_o=0, win_valid_o=0, no done_o. A new start_i then restarts at wr_addr_o=0.
- Errors:
  - Spurious res_valid_i in LOAD -> err_o=1 and stays 1 through frame completion; res_we_o stays 0 for that pulse.
  - err_o clears only after rst_i.
